// File: rtl/parity_decoder_if.sv
// Handshake bundle between the serial parity link and its decoder.
interface parity_decoder_if #(
  parameter int DATA_W    = 4,
  parameter int ERR_CNT_W = 8
);
  logic                 rx_start;
  logic                 rx_valid;
  logic                 rx_bit;
  logic [DATA_W-1:0]    out_data;
  logic                 out_valid;
  logic                 par_err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 busy;
  logic                 timeout_err;

  modport master (
    output rx_start, rx_valid, rx_bit,
    input  out_data, out_valid, par_err, err_cnt, busy, timeout_err
  );
  modport slave (
    input  rx_start, rx_valid, rx_bit,
    output out_data, out_valid, par_err, err_cnt, busy, timeout_err
  );
endinterface

// File: rtl/parity_decoder.sv
// Even-parity serial frame receiver: start strobe, DATA_W bits LSB first, parity bit.
// Optional idle-frame abort is enabled by defining PARITY_DECODER_TIMEOUT_EN.
module parity_decoder #(
  parameter int DATA_W      = 4,
  parameter int ERR_CNT_W   = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  parity_decoder_if.slave   bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_W-1:0]    shreg;
  logic                 acc;
  logic [DATA_W-1:0]    out_data;
  logic                 out_valid;
  logic                 par_err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 timeout_err;
  logic                 to_fire;
  logic                 perr_next;

  assign perr_next = acc ^ bus.rx_bit;

`ifdef PARITY_DECODER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_cnt;

  // Fires on the cycle that would make the run of idle cycles reach TIMEOUT_CYC.
  assign to_fire = (state != IDLE) && !bus.rx_start && !bus.rx_valid &&
                   (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || state == IDLE || bus.rx_start || bus.rx_valid || to_fire)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYC > 0);
  assign to_fire    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      acc         <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      par_err     <= 1'b0;
      err_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      out_valid   <= 1'b0;
      par_err     <= 1'b0;
      timeout_err <= to_fire;
      if (to_fire) begin
        state <= IDLE;
      end else if (bus.rx_start) begin
        // Start restarts from any state; a partially received frame is dropped.
        state <= DATA;
        cnt   <= '0;
        shreg <= '0;
        acc   <= 1'b0;
      end else if (bus.rx_valid) begin
        case (state)
          DATA: begin
            shreg[cnt] <= bus.rx_bit;
            acc        <= perr_next;
            if (cnt == CNT_W'(DATA_W - 1))
              state <= PARITY;
            else
              cnt <= cnt + 1'b1;
          end
          PARITY: begin
            state     <= IDLE;
            out_valid <= 1'b1;
            out_data  <= shreg;
            par_err   <= perr_next;
            if (perr_next && err_cnt != ERR_MAX)
              err_cnt <= err_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.out_data    = out_data;
  assign bus.out_valid   = out_valid;
  assign bus.par_err     = par_err;
  assign bus.err_cnt     = err_cnt;
  assign bus.busy        = (state != IDLE);
  assign bus.timeout_err = timeout_err;
endmodule
